// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared constants for the ID-stage branch resolver: opcodes, FSM encoding and
// default widths, plus opcode classification helpers.
package branch_resolve_ctrl_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int REG_AW_DEF = 5;
   localparam int CNT_W_DEF  = 32;
   localparam int OPC_W      = 6;

   localparam logic [OPC_W-1:0] OP_BLTZ = 6'h01;
   localparam logic [OPC_W-1:0] OP_BEQ  = 6'h04;
   localparam logic [OPC_W-1:0] OP_BNE  = 6'h05;
   localparam logic [OPC_W-1:0] OP_BLEZ = 6'h06;
   localparam logic [OPC_W-1:0] OP_BGTZ = 6'h07;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_ISSUE = 2'd2
   } state_e;

   function automatic logic is_branch_op(input logic [OPC_W-1:0] op);
      return op inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ};
   endfunction

   // Only the two-register compares read rt; the rest compare rs against zero.
   function automatic logic uses_rt(input logic [OPC_W-1:0] op);
      return (op == OP_BEQ) || (op == OP_BNE);
   endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// ID-stage branch bundle: instruction operands, EX/MEM writeback info, flush,
// and the stall / redirect / statistics results.
interface branch_resolve_ctrl_if
   import branch_resolve_ctrl_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int REG_AW = REG_AW_DEF,
   parameter int CNT_W  = CNT_W_DEF
);
   logic              id_valid;
   logic [OPC_W-1:0]  id_opcode;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic [XLEN-1:0]   id_rs_data;
   logic [XLEN-1:0]   id_rt_data;
   logic [XLEN-1:0]   id_target;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_reg_write;
   logic              ex_mem_read;
   logic [REG_AW-1:0] mem_rd;
   logic              mem_reg_write;
   logic              mem_mem_read;
   logic [XLEN-1:0]   mem_alu_result;
   logic              pipe_flush;
   logic              stall_if_id;
   logic              redirect_valid;
   logic [XLEN-1:0]   redirect_pc;
   logic              flush_if_id;
   logic [CNT_W-1:0]  stat_branches;
   logic [CNT_W-1:0]  stat_taken;
   logic [CNT_W-1:0]  stat_stall_cyc;

   modport master (
      output id_valid, id_opcode, id_rs, id_rt, id_rs_data, id_rt_data, id_target,
             ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_reg_write, mem_mem_read,
             mem_alu_result, pipe_flush,
      input  stall_if_id, redirect_valid, redirect_pc, flush_if_id,
             stat_branches, stat_taken, stat_stall_cyc
   );

   modport slave (
      input  id_valid, id_opcode, id_rs, id_rt, id_rs_data, id_rt_data, id_target,
             ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_reg_write, mem_mem_read,
             mem_alu_result, pipe_flush,
      output stall_if_id, redirect_valid, redirect_pc, flush_if_id,
             stat_branches, stat_taken, stat_stall_cyc
   );
endinterface

// File: rtl/branch_resolve_ctrl_cond_eval.sv
// Combinational branch condition: signed two's-complement compare of the
// selected operands, chosen by opcode.
module branch_cond_eval
   import branch_resolve_ctrl_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [OPC_W-1:0] opcode_i,
   input  logic [XLEN-1:0]  a_i,
   input  logic [XLEN-1:0]  b_i,
   output logic             taken_o
);
   // Differing signs decide by sign bit alone; equal signs reduce to unsigned order.
   function automatic logic s_lt(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
      return (x[XLEN-1] != y[XLEN-1]) ? x[XLEN-1] : (x < y);
   endfunction

   logic eq;
   logic ltz;
   logic gtz;

   always_comb begin
      eq      = (a_i == b_i);
      ltz     = s_lt(a_i, {XLEN{1'b0}});
      gtz     = s_lt({XLEN{1'b0}}, a_i);
      taken_o = 1'b0;
      case (opcode_i)
         OP_BEQ:  taken_o = eq;
         OP_BNE:  taken_o = !eq;
         OP_BLEZ: taken_o = !gtz;
         OP_BGTZ: taken_o = gtz;
         OP_BLTZ: taken_o = ltz;
         default: taken_o = 1'b0;
      endcase
   end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch sequencer: RAW stall, operand forwarding, condition evaluation
// and registered redirect. Define BRANCH_STATS_EN to build the statistics counters.
module branch_resolve_ctrl
   import branch_resolve_ctrl_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int REG_AW = REG_AW_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   branch_resolve_ctrl_if.slave bus
);
   logic              is_branch;
   logic              need_rt;
   logic              hazard;
   logic              taken;
   logic [REG_AW-1:0] src_idx [2];
   logic [XLEN-1:0]   rf_data [2];
   logic [XLEN-1:0]   opnd    [2];
   logic [1:0]        hz;

   assign is_branch  = bus.id_valid && is_branch_op(bus.id_opcode);
   assign need_rt    = uses_rt(bus.id_opcode);
   assign src_idx[0] = bus.id_rs;
   assign src_idx[1] = bus.id_rt;
   assign rf_data[0] = bus.id_rs_data;
   assign rf_data[1] = bus.id_rt_data;

   // A MEM load is not yet forwardable, so it stalls; a MEM ALU result forwards.
   for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
      logic live;
      logic ex_hit;
      logic mem_hit;
      assign live     = (src_idx[gi] != '0);
      assign ex_hit   = live && (src_idx[gi] == bus.ex_rd) && (bus.ex_reg_write || bus.ex_mem_read);
      assign mem_hit  = live && (src_idx[gi] == bus.mem_rd);
      assign hz[gi]   = ex_hit || (mem_hit && bus.mem_mem_read);
      assign opnd[gi] = (mem_hit && bus.mem_reg_write && !bus.mem_mem_read)
                        ? bus.mem_alu_result : rf_data[gi];
   end

   assign hazard = is_branch && (hz[0] || (need_rt && hz[1]));

   branch_cond_eval #(.XLEN(XLEN)) u_cond (
      .opcode_i (bus.id_opcode),
      .a_i      (opnd[0]),
      .b_i      (opnd[1]),
      .taken_o  (taken)
   );

   state_e          state_q, state_d;
   logic            stall;
   logic            resolve;
   logic            redirect_valid_q;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

   always_comb begin
      state_d       = state_q;
      stall         = 1'b0;
      resolve       = 1'b0;
      redirect_pc_d = redirect_pc_q;
      case (state_q)
         ST_IDLE, ST_HOLD: begin
            if (!is_branch) begin
               state_d = ST_IDLE;
            end else if (hazard) begin
               stall   = 1'b1;
               state_d = ST_HOLD;
            end else begin
               resolve = 1'b1;
               state_d = taken ? ST_ISSUE : ST_IDLE;
            end
         end
         // The instruction in ID during ISSUE is on the wrong path and is ignored.
         ST_ISSUE: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (bus.pipe_flush) begin
         state_d = ST_IDLE;
         stall   = 1'b0;
         resolve = 1'b0;
      end
      if (resolve && taken) begin
         redirect_pc_d = bus.id_target;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= ST_IDLE;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         state_q          <= state_d;
         redirect_valid_q <= resolve && taken;
         redirect_pc_q    <= redirect_pc_d;
      end
   end

   assign bus.stall_if_id    = stall;
   assign bus.redirect_valid = redirect_valid_q;
   assign bus.flush_if_id    = redirect_valid_q;
   assign bus.redirect_pc    = redirect_pc_q;

`ifdef BRANCH_STATS_EN
   logic [CNT_W-1:0] br_cnt_q, tk_cnt_q, st_cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         br_cnt_q <= '0;
         tk_cnt_q <= '0;
         st_cnt_q <= '0;
      end else begin
         if (resolve)          br_cnt_q <= br_cnt_q + CNT_W'(1);
         if (resolve && taken) tk_cnt_q <= tk_cnt_q + CNT_W'(1);
         if (stall)            st_cnt_q <= st_cnt_q + CNT_W'(1);
      end
   end

   assign bus.stat_branches  = br_cnt_q;
   assign bus.stat_taken     = tk_cnt_q;
   assign bus.stat_stall_cyc = st_cnt_q;
`else
   assign bus.stat_branches  = {CNT_W{1'b0}};
   assign bus.stat_taken     = {CNT_W{1'b0}};
   assign bus.stat_stall_cyc = {CNT_W{1'b0}};
`endif

endmodule
